// File: rtl/cpu_0_div_pkg.sv
// cpu_0_div_pkg -- shared definitions for the radix-2 restoring divider.
// Contents: sequencer state encoding, default operand width, and the
// constants that define the divide-by-zero result.
// Ports: none (package).
package cpu_0_div_pkg;

  // Default operand/result width of the divider.
  localparam int DEF_DATA_W = 32;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  // Divide by zero: every quotient bit takes this value (all ones).
  localparam logic DIV0_QUOT_BIT = 1'b1;
  // Divide by zero: the remainder passes the dividend through unchanged.
  localparam logic DIV0_REM_IS_DIVIDEND = 1'b1;

endpackage

// File: rtl/cpu_0_div_step.sv
// cpu_0_div_step -- one combinational restoring-division iteration.
// Shifts the next dividend bit into the partial remainder, trial-subtracts
// the divisor, keeps the difference when it is non-negative and reports
// the resulting quotient bit.
// Ports:
//   rem_in       partial remainder before this step (DATA_W+1 bits)
//   dividend_bit next dividend bit, MSB first
//   divisor      divisor magnitude
//   rem_out      partial remainder after this step
//   quot_bit     quotient bit produced by this step
module cpu_0_div_step
  import cpu_0_div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W:0]   rem_in,
  input  logic              dividend_bit,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_out,
  output logic              quot_bit
);

  logic [DATA_W:0]   shifted_s;
  logic [DATA_W+1:0] trial_s;
  logic              unused_s;

  // The remainder is always below the divisor, so its top bit is zero
  // before the shift and can be dropped.
  assign unused_s  = rem_in[DATA_W];
  assign shifted_s = {rem_in[DATA_W-1:0], dividend_bit};
  // One extra bit so the borrow shows up as the sign of the trial result.
  assign trial_s   = {1'b0, shifted_s} - {2'b00, divisor};
  assign quot_bit  = ~trial_s[DATA_W+1];
  assign rem_out   = quot_bit ? trial_s[DATA_W:0] : shifted_s;

endmodule

// File: rtl/cpu_0_div_cell.sv
// cpu_0_div_cell -- multi-cycle radix-2 restoring divider.
// A start pulse in IDLE or DONE latches the operands; ITERS CALC cycles
// run one shift-subtract step each, FIX applies the sign correction and
// the divide-by-zero override, and DONE pulses done for one cycle.
// Latency is fixed: start in cycle 0 gives done in cycle ITERS+2.
// Build option: define CPU_0_DIV_CELL_SIGNED_EN to honour A_div_signed;
// without it every operation is unsigned and no abs/negate logic exists.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   A_div_start         request pulse (ignored while busy)
//   A_div_signed        two's-complement operation, sampled with start
//   A_div_src1/src2     dividend / divisor, sampled with start
//   A_div_busy          high in CALC and FIX
//   A_div_done          one-cycle completion pulse
//   A_div_quotient      registered quotient, held until the next done
//   A_div_remainder     registered remainder, held until the next done
module cpu_0_div_cell
  import cpu_0_div_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ITERS  = DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              A_div_start,
  input  logic              A_div_signed,
  input  logic [DATA_W-1:0] A_div_src1,
  input  logic [DATA_W-1:0] A_div_src2,
  output logic              A_div_busy,
  output logic              A_div_done,
  output logic [DATA_W-1:0] A_div_quotient,
  output logic [DATA_W-1:0] A_div_remainder
);

  localparam int CNT_W = $clog2(ITERS + 1);

  div_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] dq_r;     // dividend shifts out at the top, quotient bits enter at the bottom
  logic [DATA_W-1:0] dvs_r;
  logic [DATA_W:0]   rem_r;
  logic              div0_r;
  logic              busy_r;
  logic              done_r;
  logic [DATA_W-1:0] quotient_r;
  logic [DATA_W-1:0] remainder_r;

  logic [DATA_W-1:0] abs1_s;
  logic [DATA_W-1:0] abs2_s;
  logic [DATA_W-1:0] quot_fix_s;
  logic [DATA_W-1:0] rem_fix_s;
  logic [DATA_W:0]   rem_next_s;
  logic              qbit_s;

`ifdef CPU_0_DIV_CELL_SIGNED_EN
  logic neg1_s;
  logic neg2_s;
  logic q_neg_r;
  logic r_neg_r;

  assign neg1_s = A_div_signed & A_div_src1[DATA_W-1];
  assign neg2_s = A_div_signed & A_div_src2[DATA_W-1];
  assign abs1_s = neg1_s ? ({DATA_W{1'b0}} - A_div_src1) : A_div_src1;
  assign abs2_s = neg2_s ? ({DATA_W{1'b0}} - A_div_src2) : A_div_src2;
  // Remainder follows the dividend's sign; negating the magnitude of a
  // divide-by-zero remainder restores the original dividend.
  assign rem_fix_s  = r_neg_r ? ({DATA_W{1'b0}} - rem_r[DATA_W-1:0]) : rem_r[DATA_W-1:0];
  assign quot_fix_s = div0_r  ? {DATA_W{DIV0_QUOT_BIT}}
                    : (q_neg_r ? ({DATA_W{1'b0}} - dq_r) : dq_r);
`else
  logic unused_s;

  assign unused_s   = A_div_signed;
  assign abs1_s     = A_div_src1;
  assign abs2_s     = A_div_src2;
  assign rem_fix_s  = rem_r[DATA_W-1:0];
  assign quot_fix_s = div0_r ? {DATA_W{DIV0_QUOT_BIT}} : dq_r;
`endif

  cpu_0_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem_in       (rem_r),
    .dividend_bit (dq_r[DATA_W-1]),
    .divisor      (dvs_r),
    .rem_out      (rem_next_s),
    .quot_bit     (qbit_s)
  );

  // Sequencer, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      dq_r        <= {DATA_W{1'b0}};
      dvs_r       <= {DATA_W{1'b0}};
      rem_r       <= {(DATA_W+1){1'b0}};
      div0_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= {DATA_W{1'b0}};
      remainder_r <= {DATA_W{1'b0}};
`ifdef CPU_0_DIV_CELL_SIGNED_EN
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (A_div_start) begin
            state_r <= ST_CALC;
            busy_r  <= 1'b1;
            cnt_r   <= {CNT_W{1'b0}};
            dq_r    <= abs1_s;
            dvs_r   <= abs2_s;
            rem_r   <= {(DATA_W+1){1'b0}};
            div0_r  <= (A_div_src2 == {DATA_W{1'b0}});
`ifdef CPU_0_DIV_CELL_SIGNED_EN
            q_neg_r <= neg1_s ^ neg2_s;
            r_neg_r <= neg1_s;
`endif
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_CALC: begin
          rem_r <= rem_next_s;
          dq_r  <= {dq_r[DATA_W-2:0], qbit_s};
          if (cnt_r == CNT_W'(ITERS - 1)) begin
            state_r <= ST_FIX;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
          end
        end
        ST_FIX: begin
          quotient_r  <= quot_fix_s;
          remainder_r <= rem_fix_s;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
          state_r     <= ST_DONE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign A_div_busy      = busy_r;
  assign A_div_done      = done_r;
  assign A_div_quotient  = quotient_r;
  assign A_div_remainder = remainder_r;

endmodule

// File: tb/tb_cpu_0_div_cell.sv
// tb_cpu_0_div_cell -- self-checking bench for cpu_0_div_cell at default
// parameters. Expected results come from a plain-arithmetic reference
// model; signed expectations follow CPU_0_DIV_CELL_SIGNED_EN.
module tb_cpu_0_div_cell;

  localparam int LAT = 34;
`ifdef CPU_0_DIV_CELL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_0_div_cell dut (
    .clk             (clk),
    .reset           (reset),
    .A_div_start     (start),
    .A_div_signed    (sgn),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quot),
    .A_div_remainder (rem)
  );

  // Reference: truncating division, remainder with the dividend's sign,
  // divide by zero gives all ones and the dividend.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s && SIGNED_EN) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  // Launch one operation in cycle 0 and watch until done (bounded).
  // With noise set, random start pulses and operands are driven while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit s, input bit noise,
                        output int done_cyc, output int busy_bad,
                        output logic [31:0] q, output logic [31:0] r);
    @(posedge clk); #1;
    start = 1'b1; src1 = a; src2 = b; sgn = s;
    done_cyc = -1; busy_bad = 0; q = 32'd0; r = 32'd0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cyc = c; q = quot; r = rem;
        if (busy) busy_bad++;
        break;
      end
      if (c < LAT && !busy) busy_bad++;
      if (noise && c < LAT) begin
        start = 1'($urandom_range(0, 1)); src1 = $urandom; src2 = $urandom; sgn = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; sgn = 1'b0; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (quot !== 32'd0) begin errors++; $display("FAIL reset_quot: got %h expected 0", quot); end
    checks++; if (rem !== 32'd0) begin errors++; $display("FAIL reset_rem: got %h expected 0", rem); end
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_prio: busy got %b expected 0", busy); end
  endtask

  task automatic test_directed;
    logic [31:0] ta [5] = '{32'd100, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] tb [5] = '{32'd7,   32'd0, 32'd0,         32'd2,         32'hFFFF_FFFF};
    bit          ts [5] = '{1'b0,    1'b0,  1'b1,          1'b1,          1'b1};
    logic [31:0] eq [5] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC,
                            SIGNED_EN ? 32'h8000_0000 : 32'd0};
    logic [31:0] er [5] = '{32'd2, 32'd5, 32'hFFFF_FFFB,
                            SIGNED_EN ? 32'hFFFF_FFFF : 32'd1,
                            SIGNED_EN ? 32'd0 : 32'h8000_0000};
    int dc, bb;
    logic [31:0] q, r;
    for (int i = 0; i < 5; i++) begin
      run_op(ta[i], tb[i], ts[i], 1'b0, dc, bb, q, r);
      checks++; if (dc !== LAT) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, dc, LAT); end
      checks++; if (bb !== 0) begin errors++; $display("FAIL dir%0d_busy: got %0d bad cycles expected 0", i, bb); end
      checks++; if (q !== eq[i]) begin errors++; $display("FAIL dir%0d_quot: got %h expected %h", i, q, eq[i]); end
      checks++; if (r !== er[i]) begin errors++; $display("FAIL dir%0d_rem: got %h expected %h", i, r, er[i]); end
    end
  endtask

  task automatic test_random;
    int dc, bb, hold_bad;
    logic [31:0] a, b, q, r;
    logic [63:0] exp;
    bit s, noise;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0;
        default: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
      endcase
      s = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      exp = ref_div(a, b, s);
      run_op(a, b, s, noise, dc, bb, q, r);
      checks++; if (dc !== LAT || bb !== 0) begin errors++; $display("FAIL rnd%0d_timing: got done %0d busybad %0d expected %0d 0", i, dc, bb, LAT); end
      checks++; if (q !== exp[63:32]) begin errors++; $display("FAIL rnd%0d_quot: %h/%h s=%b got %h expected %h", i, a, b, s, q, exp[63:32]); end
      checks++; if (r !== exp[31:0]) begin errors++; $display("FAIL rnd%0d_rem: %h/%h s=%b got %h expected %h", i, a, b, s, r, exp[31:0]); end
      hold_bad = 0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        if (done !== 1'b0 || quot !== exp[63:32] || rem !== exp[31:0]) hold_bad++;
      end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d bad idle cycles expected 0", i, hold_bad); end
    end
  endtask

  task automatic test_back_to_back;
    int d2, stray, bbad;
    @(posedge clk); #1;
    start = 1'b1; src1 = 32'd100; src2 = 32'd7; sgn = 1'b0;
    d2 = -1; stray = 0; bbad = 0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == LAT) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", done); end
        checks++; if (quot !== 32'd14 || rem !== 32'd2) begin errors++; $display("FAIL b2b_res1: got %h %h expected e 2", quot, rem); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_done: got %b expected 0", busy); end
        src1 = 32'd9; src2 = 32'd3;
      end else if (done) begin
        if (c > LAT && d2 < 0) d2 = c; else stray++;
        if (c > LAT) begin
          checks++; if (quot !== 32'd3 || rem !== 32'd0) begin errors++; $display("FAIL b2b_res2: got %h %h expected 3 0", quot, rem); end
        end
      end else if (!busy && c < 2 * LAT) begin
        bbad++;
      end
      if (c == 60) start = 1'b0;
    end
    start = 1'b0;
    checks++; if (d2 !== 2 * LAT) begin errors++; $display("FAIL b2b_done2_cycle: got %0d expected %0d", d2, 2 * LAT); end
    checks++; if (stray !== 0 || bbad !== 0) begin errors++; $display("FAIL b2b_ignored_start: got %0d stray done %0d idle cycles expected 0 0", stray, bbad); end
  endtask

  task automatic test_reset_mid;
    int seen;
    @(posedge clk); #1;
    start = 1'b1; src1 = 32'd100; src2 = 32'd7; sgn = 1'b0;
    seen = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 11) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (quot !== 32'd0 || rem !== 32'd0) begin errors++; $display("FAIL abort_outputs: got %h %h expected 0 0", quot, rem); end
        reset = 1'b0;
      end
      if (done) seen++;
      if (c == 10) reset = 1'b1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", seen); end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; sgn = 1'b0; src1 = 32'd0; src2 = 32'd0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_0_div_cell.md
CPU_0_DIV_CELL -- requirements
Module: cpu_0_div_cell

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter ITERS, default DATA_W, number of radix-2 iteration cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port A_div_start  input  1  request pulse; accepted only in IDLE or DONE.
REQ-006 SHALL have port A_div_signed  input  1  1 = two's-complement operation, sampled with start.
REQ-007 SHALL have port A_div_src1  input  DATA_W  dividend, sampled with start.
REQ-008 SHALL have port A_div_src2  input  DATA_W  divisor, sampled with start.
REQ-009 SHALL have port A_div_busy  output  1  high in CALC and FIX.
REQ-010 SHALL have port A_div_done  output  1  one-cycle pulse; results valid in that cycle.
REQ-011 SHALL have port A_div_quotient  output  DATA_W  registered quotient.
REQ-012 SHALL have port A_div_remainder  output  DATA_W  registered remainder.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE.
- IDLE + start -> CALC.
- CALC -> FIX after ITERS cycles.
- FIX -> DONE.
- DONE + start -> CALC; otherwise DONE -> IDLE.
REQ-014 SHALL, on acceptance, latch the operands and their absolute values, and SHALL compute quotient and remainder signs from the latched signed flag.
REQ-015 SHALL perform one restoring shift-subtract step per CALC cycle, MSB first, using a DATA_W+1-bit partial remainder.
REQ-016 SHALL apply the sign fix-up in FIX:
- quotient negated when operand signs differ;
- remainder takes the dividend's sign.
REQ-017 SHALL have a fixed latency, independent of operand values: start sampled in cycle 0 -> done high in cycle ITERS+2 (34 at default).
REQ-018 SHALL ignore start while busy: no restart and no operand re-sampling.
REQ-019 SHALL hold quotient/remainder stable from done until the next done.
REQ-020 SHALL return quotient all-ones and remainder = dividend for divisor 0, with normal latency, in both signed and unsigned modes.
REQ-021 SHALL return quotient 0x80000000 and remainder 0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-022 SHALL accept back-to-back operations: start in the DONE cycle gives the next done exactly ITERS+2 cycles later.

Reset
REQ-023 SHALL, on reset, set state IDLE, busy 0, done 0, quotient 0, remainder 0, and iteration counter 0.
REQ-024 SHALL abort an operation reset mid-operation without producing a done pulse; reset SHALL take priority over a simultaneous start.

Configuration
REQ-025 SHALL support signed operation only when macro CPU_0_DIV_CELL_SIGNED_EN is defined.
- Defined: A_div_signed is honoured.
- Undefined: the A_div_signed port remains, is ignored, all operations are unsigned, and no abs/negate logic is built.

Structure
REQ-026 SHALL place the state enum, DATA_W default, and divide-by-zero result constants in shared package cpu_0_div_pkg.
REQ-027 SHALL implement one restoring iteration (shift, trial subtract, select, quotient bit) as combinational sub-module cpu_0_div_step.

Verification
REQ-028 SHALL cover unsigned 100/7 -> quotient 14, remainder 2, done at cycle 34, busy high in cycles 1-33.
REQ-029 SHALL cover unsigned 5/0 -> quotient 0xFFFFFFFF, remainder 5, done at cycle 34.
REQ-030 SHALL cover signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; with CPU_0_DIV_CELL_SIGNED_EN undefined -> quotient 0x7FFFFFFC, remainder 1.
REQ-031 SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-032 SHALL cover start held high across the first operation (100/7, then 9/3 start in DONE cycle) -> second done at cycle 68 with quotient 3, remainder 0; start pulses in cycles 1-33 ignored.
REQ-033 SHALL cover reset asserted in cycle 10 of 100/7 -> busy 0 from cycle 11, no done pulse, outputs 0.
